// File: rtl/shift_add_mul64.sv
// rtl/shift_add_mul64.sv - radix-2 iterative shift-add 64x64 multiplier, signed/unsigned
module brent_kung_add64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [64:0] sum
);
    logic [63:0] g0;
    logic [63:0] p0;
    logic [63:0] gx;
    logic [63:0] px;

    // In-place prefix tree: up-sweep builds power-of-two spans, down-sweep fills the rest.
    always_comb begin
        g0 = a & b;
        p0 = a ^ b;
        gx = g0;
        px = p0;
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < 64; i++) begin
                if (((i + 1) & ((2 << l) - 1)) == 0) begin
                    gx[i] = gx[i] | (px[i] & gx[i - (1 << l)]);
                    px[i] = px[i] & px[i - (1 << l)];
                end
            end
        end
        for (int l = 4; l >= 0; l--) begin
            for (int i = 0; i < 64; i++) begin
                if ((i >= (2 << l)) && (((i + 1) & ((2 << l) - 1)) == (1 << l))) begin
                    gx[i] = gx[i] | (px[i] & gx[i - (1 << l)]);
                    px[i] = px[i] & px[i - (1 << l)];
                end
            end
        end
        sum = '0;
        sum[0] = p0[0];
        for (int i = 1; i < 64; i++) begin
            sum[i] = p0[i] ^ gx[i - 1];
        end
        sum[64] = gx[63];
    end
endmodule

module shift_add_mul64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);
    typedef enum logic [1:0] {IDLE, BUSY, NEG, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic        neg;
    logic [63:0] acc_hi;
    logic [63:0] acc_lo;
    logic [63:0] mcand;
    logic [63:0] addend;
    logic [64:0] sum;

    // Two's complement without a carry chain: invert every bit above the lowest set bit.
    function automatic logic [127:0] negate128(input logic [127:0] x);
        logic [127:0] r;
        logic         seen;
        r    = '0;
        seen = 1'b0;
        for (int i = 0; i < 128; i++) begin
            r[i] = x[i] ^ seen;
            seen = seen | x[i];
        end
        return r;
    endfunction

    function automatic logic [63:0] abs64(input logic [63:0] x);
        logic [127:0] n;
        n = negate128({64'd0, x});
        return x[63] ? n[63:0] : x;
    endfunction

    assign addend = acc_lo[0] ? mcand : 64'd0;

    brent_kung_add64 u_add (
        .a   (acc_hi),
        .b   (addend),
        .sum (sum)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign prod_hi   = acc_hi;
    assign prod_lo   = acc_lo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            neg    <= 1'b0;
            acc_hi <= 64'd0;
            acc_lo <= 64'd0;
            mcand  <= 64'd0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= 6'd0;
                        acc_hi <= 64'd0;
                        if (in_signed) begin
                            mcand  <= abs64(op_a);
                            acc_lo <= abs64(op_b);
                            neg    <= op_a[63] ^ op_b[63];
                        end else begin
                            mcand  <= op_a;
                            acc_lo <= op_b;
                            neg    <= 1'b0;
                        end
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    {acc_hi, acc_lo} <= {sum, acc_lo[63:1]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= neg ? NEG : DONE;
                    end
                end
                NEG: begin
                    {acc_hi, acc_lo} <= negate128({acc_hi, acc_lo});
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/shift_add_mul64.md
SHIFT_ADD_MUL64 -- requirements
Module: shift_add_mul64

Interface
REQ-001 Parameter: WIDTH, default 64, operand width; only 64 is supported.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  aborts any operation in progress.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_signed  input  1  1 = both operands two's-complement; 0 = both unsigned.
REQ-008 op_a  input  64  multiplicand.
REQ-009 op_b  input  64  multiplier.
REQ-010 out_valid  output  1  product available.
REQ-011 out_ready  input  1  consumer accepts the product.
REQ-012 prod_hi  output  64  product bits [127:64].
REQ-013 prod_lo  output  64  product bits [63:0].

Function
REQ-014 The block SHALL be a radix-2 iterative shift-add multiplier, one multiplier bit per cycle.
REQ-015 Accumulation SHALL use one instance of the 64-bit Brent-Kung adder (zero carry-in, 65-bit sum); no other 64-bit adder SHALL exist in the datapath.
REQ-016 States SHALL be IDLE, BUSY, NEG, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid & in_ready, latch operands and go to BUSY with iteration counter = 0.
REQ-018 Capture in signed mode: latch |op_a|, |op_b| and neg = op_a[63] ^ op_b[63]; in unsigned mode latch raw operands, neg = 0.
REQ-019 Absolute value of 0x8000_0000_0000_0000 SHALL be 0x8000_0000_0000_0000, interpreted as unsigned 2^63.
REQ-020 Registers: acc_hi (64), acc_lo (64, initialised to the latched multiplier), mcand (64).
REQ-021 Each BUSY cycle: sum = acc_lo[0] ? acc_hi + mcand (65 bits) : {1'b0, acc_hi}; then {acc_hi, acc_lo} <= {sum, acc_lo[63:1]}, i.e. a right shift of 129 bits; counter increments.
REQ-022 After the 64th BUSY cycle (counter = 63), go to NEG if neg = 1, else to DONE.
REQ-023 NEG: in one cycle, replace the 128-bit {acc_hi, acc_lo} with its two's complement, then go to DONE.
REQ-024 DONE: prod_hi/prod_lo = {acc_hi, acc_lo}, held stable while out_valid & !out_ready.
REQ-025 On out_valid & out_ready, go to IDLE; a new operand SHALL NOT be accepted in that same cycle.
REQ-026 Latency: operand handshake at edge T; out_valid rises after edge T+64 (unsigned or neg = 0) or after edge T+65 (neg = 1).
REQ-027 Signed result SHALL equal the exact 128-bit two's-complement product; unsigned result SHALL equal the exact 128-bit unsigned product.
REQ-028 Operand inputs SHALL be ignored outside the IDLE handshake; changes to them during BUSY SHALL have no effect.
REQ-029 flush = 1 in any state SHALL force IDLE on the next edge and discard the result; flush takes priority over both handshakes in the same cycle.
REQ-030 A product held in DONE SHALL be discarded by flush; out_valid is 0 in the following cycle.
REQ-031 The block SHALL contain no early termination: latency is independent of operand values.

Reset
REQ-032 With rst = 1 at an edge: state = IDLE; acc_hi, acc_lo, mcand, counter and neg = 0; out_valid = 0; in_ready = 1; prod_hi = prod_lo = 0.
REQ-033 Reset asserted mid-operation SHALL abort it with no output pulse; rst overrides flush and both handshakes.

Verification
REQ-034 Unsigned: op_a = 0xFFFF_FFFF_FFFF_FFFF, op_b = 0xFFFF_FFFF_FFFF_FFFF -> after 64 cycles prod_hi = 0xFFFF_FFFF_FFFF_FFFE, prod_lo = 0x0000_0000_0000_0001.
REQ-035 Signed: op_a = -3, op_b = 7 -> after 65 cycles prod_hi = 0xFFFF_FFFF_FFFF_FFFF, prod_lo = 0xFFFF_FFFF_FFFF_FFEB; op_a = -3, op_b = -7 -> after 64 cycles prod = 21.
REQ-036 Signed corner: op_a = op_b = 0x8000_0000_0000_0000 -> prod_hi = 0x4000_0000_0000_0000, prod_lo = 0.
REQ-037 Back-pressure: hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0; then out_ready = 1 for 1 cycle -> IDLE next cycle.
REQ-038 Abort: flush at BUSY cycle 30, then rst asserted during a later BUSY -> no out_valid in either case, IDLE next cycle; the next operation (5 x 6) returns 30.
REQ-039 Random: 10,000 random signed and unsigned pairs with random out_ready stalls, compared to a 128-bit reference model.
